// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: state encodings (ST_*) and operation encodings (OP_*) shared by the arbiter
package mem_arbiter_pkg;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;
  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;
endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// rr_pick2: two-way round-robin select; valid0_i/valid1_i/last_i in, grant_o/grant_id_o out
module rr_pick2 (
  input  logic valid0_i,
  input  logic valid1_i,
  input  logic last_i,
  output logic grant_o,
  output logic grant_id_o
);
  assign grant_o    = valid0_i | valid1_i;
  assign grant_id_o = (valid0_i & valid1_i) ? ~last_i : valid1_i;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin share of one memory port (maddr/mout/min/mre/mwe/mready) between two requester ports (addrN/dinN/doutN/reN/weN/readyN)
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 64,
  parameter int WORD_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [WORD_WIDTH-1:0] din0,
  output logic [WORD_WIDTH-1:0] dout0,
  input  logic                  re0,
  input  logic                  we0,
  output logic                  ready0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [WORD_WIDTH-1:0] din1,
  output logic [WORD_WIDTH-1:0] dout1,
  input  logic                  re1,
  input  logic                  we1,
  output logic                  ready1,
  output logic [ADDR_WIDTH-1:0] maddr,
  output logic [WORD_WIDTH-1:0] mout,
  input  logic [WORD_WIDTH-1:0] min,
  output logic                  mre,
  output logic                  mwe,
  input  logic                  mready
);
  logic [1:0] state_q, state_d, mask_q, ready_q;
  logic last_q, gid_q, op_q, mre_q, mwe_q, grant, gid, wr;
  logic [ADDR_WIDTH-1:0] maddr_q;
  logic [WORD_WIDTH-1:0] mout_q, dout0_q, dout1_q;
  rr_pick2 u_pick (
    .valid0_i  ((re0 | we0) & ~mask_q[0]),
    .valid1_i  ((re1 | we1) & ~mask_q[1]),
    .last_i    (last_q),
    .grant_o   (grant),
    .grant_id_o(gid)
  );
  // a write wins over a read when both strobes are raised together
  assign wr = gid ? we1 : we0;
  always_comb
    state_d = (state_q == ST_IDLE)  ? (grant ? ST_ISSUE : ST_IDLE) :
              (state_q == ST_ISSUE) ? ST_WAIT :
              (state_q == ST_WAIT)  ? (mready ? ST_RESP : ST_WAIT) : ST_IDLE;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      mask_q  <= '0;
      ready_q <= '0;
      last_q  <= 1'b0;
      gid_q   <= 1'b0;
      op_q    <= OP_READ;
      mre_q   <= 1'b0;
      mwe_q   <= 1'b0;
      maddr_q <= '0;
      mout_q  <= '0;
      dout0_q <= '0;
      dout1_q <= '0;
    end else begin
      state_q <= state_d;
      mre_q   <= 1'b0;
      mwe_q   <= 1'b0;
      ready_q <= '0;
      case (state_q)
        ST_IDLE: begin
          // the served port is masked for exactly one IDLE cycle, granted or not
          mask_q <= '0;
          if (grant) begin
            gid_q   <= gid;
            op_q    <= wr;
            maddr_q <= gid ? addr1 : addr0;
            mout_q  <= gid ? din1 : din0;
            mre_q   <= (wr == OP_READ);
            mwe_q   <= (wr == OP_WRITE);
          end
        end
        ST_WAIT: if (mready) begin
          ready_q[gid_q] <= 1'b1;
          if (op_q == OP_READ && !gid_q) dout0_q <= min;
          if (op_q == OP_READ && gid_q) dout1_q <= min;
        end
        ST_RESP: begin
          last_q         <= gid_q;
          mask_q[gid_q]  <= 1'b1;
        end
        default: ;
      endcase
    end
  end
  assign maddr  = maddr_q;
  assign mout   = mout_q;
  assign mre    = mre_q;
  assign mwe    = mwe_q;
  assign ready0 = ready_q[0];
  assign ready1 = ready_q[1];
  assign dout0  = dout0_q;
  assign dout1  = dout1_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized and directed checks of mem_arbiter against a transaction-phase reference model
module tb_mem_arbiter;
  localparam int AW = 64;
  localparam int WW = 64;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0, maddr;
  logic [WW-1:0] din0 = '0, din1 = '0, dout0, dout1, mout, min = '0;
  logic re0 = 1'b0, we0 = 1'b0, re1 = 1'b0, we1 = 1'b0, mready = 1'b0;
  logic ready0, ready1, mre, mwe;
  int checks = 0;
  int passed = 0;
  bit req_re[2], req_we[2], seen_rdy[2];
  logic [63:0] req_a[2], req_d[2], dexp[2];
  int phase = 0;
  int cnt = 0;
  bit gid, op, last, mask_v, mask_p;
  logic [63:0] a_exp, d_exp, rd_val;
  bit rand_req = 0;
  int action_force = 0;
  int force_delay = 0;
  bit force_min_en = 0;
  logic [63:0] force_min = '0;
  mem_arbiter #(.ADDR_WIDTH(AW), .WORD_WIDTH(WW)) dut (
    .clk(clk), .rst(rst),
    .addr0(addr0), .din0(din0), .dout0(dout0), .re0(re0), .we0(we0), .ready0(ready0),
    .addr1(addr1), .din1(din1), .dout1(dout1), .re1(re1), .we1(we1), .ready1(ready1),
    .maddr(maddr), .mout(mout), .min(min), .mre(mre), .mwe(mwe), .mready(mready)
  );
  always #5 clk = ~clk;
  a_hold0: assert property (@(posedge clk) disable iff (!rst) ((re0 | we0) && !ready0) |=> (re0 | we0));
  a_hold1: assert property (@(posedge clk) disable iff (!rst) ((re1 | we1) && !ready1) |=> (re1 | we1));
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask
  task automatic drive();
    re0 = req_re[0]; we0 = req_we[0]; addr0 = req_a[0]; din0 = req_d[0];
    re1 = req_re[1]; we1 = req_we[1]; addr1 = req_a[1]; din1 = req_d[1];
  endtask
  task automatic set_req(input int n, input bit r, input bit w, input logic [63:0] a, input logic [63:0] d);
    req_re[n] = r; req_we[n] = w; req_a[n] = a; req_d[n] = d;
  endtask
  task automatic new_req(input int n);
    int k;
    k = $urandom_range(2);
    set_req(n, k != 1, k != 0, {$urandom, $urandom}, {$urandom, $urandom});
  endtask
  task automatic reset_model();
    phase = 0; last = 0; mask_v = 0;
    dexp[0] = '0; dexp[1] = '0;
    seen_rdy[0] = 0; seen_rdy[1] = 0;
  endtask
  // Called at posedge+1: checks the current cycle, drives its inputs, advances the model.
  task automatic step();
    bit v0, v1;
    if (phase == 3 && !op) dexp[gid] = rd_val;
    check("mre", mre, phase == 1 && !op);
    check("mwe", mwe, phase == 1 && op);
    if (phase == 1) begin
      check("maddr", maddr, a_exp);
      check("mout", mout, d_exp);
    end
    check("ready0", ready0, phase == 3 && !gid);
    check("ready1", ready1, phase == 3 && gid);
    check("dout0", dout0, dexp[0]);
    check("dout1", dout1, dexp[1]);
    for (int n = 0; n < 2; n++) begin
      if (seen_rdy[n]) begin
        int sel;
        seen_rdy[n] = 0;
        sel = (action_force >= 0) ? action_force : int'($urandom_range(2));
        if (sel == 0) begin req_re[n] = 0; req_we[n] = 0; end
        else if (sel == 2) new_req(n);
      end else if (rand_req && !(req_re[n] | req_we[n]) && $urandom_range(2) == 0) new_req(n);
    end
    if (phase == 3) seen_rdy[gid] = 1;
    drive();
    min = force_min_en ? force_min : {$urandom, $urandom};
    mready = (phase == 2) ? (cnt == 0) : 1'b1;
    case (phase)
      0: begin
        v0 = (req_re[0] | req_we[0]) && !(mask_v && !mask_p);
        v1 = (req_re[1] | req_we[1]) && !(mask_v && mask_p);
        mask_v = 0;
        if (v0 || v1) begin
          gid = (v0 && v1) ? !last : v1;
          op = req_we[gid];
          a_exp = req_a[gid];
          d_exp = req_d[gid];
          phase = 1;
        end
      end
      1: begin
        cnt = (force_delay >= 0) ? force_delay : int'($urandom_range(3));
        phase = 2;
      end
      2: if (cnt == 0) begin rd_val = min; phase = 3; end else cnt--;
      default: begin last = gid; mask_v = 1; mask_p = gid; phase = 0; end
    endcase
    @(posedge clk); #1;
  endtask
  task automatic check_cleared();
    check("rst_mre", mre, 0);
    check("rst_mwe", mwe, 0);
    check("rst_ready0", ready0, 0);
    check("rst_ready1", ready1, 0);
    check("rst_dout0", dout0, 0);
    check("rst_dout1", dout1, 0);
    check("rst_maddr", maddr, 0);
    check("rst_mout", mout, 0);
  endtask
  initial begin
    reset_model();
    set_req(0, 1, 0, 64'h40, 64'h0);
    set_req(1, 0, 0, 64'h0, 64'h0);
    drive();
    mready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_cleared();
    rst = 1'b1;
    force_min_en = 1; force_min = 64'hDEAD;
    repeat (6) step();
    set_req(0, 1, 0, 64'h200, 64'h11);
    set_req(1, 0, 1, 64'h300, 64'h22);
    force_min_en = 0; action_force = 1;
    repeat (20) step();
    action_force = 0;
    repeat (16) step();
    set_req(1, 0, 1, 64'h100, 64'h55);
    force_delay = 5;
    repeat (14) step();
    force_delay = 0;
    set_req(0, 1, 0, 64'h80, 64'h0);
    action_force = 1;
    repeat (12) step();
    action_force = 0;
    repeat (8) step();
    rand_req = 1; action_force = -1; force_delay = -1;
    repeat (1500) step();
    rand_req = 0; action_force = 0;
    repeat (40) step();
    force_delay = 10;
    set_req(0, 1, 0, 64'h44, 64'h0);
    for (int i = 0; i < 12 && phase != 2; i++) step();
    check("reach_wait", phase, 2);
    step();
    step();
    rst = 1'b0;
    set_req(0, 0, 0, 64'h0, 64'h0);
    set_req(1, 0, 0, 64'h0, 64'h0);
    drive();
    mready = 1'b1;
    #1;
    check_cleared();
    reset_model();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (12) step();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
